// File: rtl/alu_seq_multiplier.sv
// rtl/alu_seq_multiplier.sv - iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH
module alu_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_neg;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;

    logic             w_load;
    logic             w_last;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_acc_sum;
    logic [PW-1:0]    w_product;

    assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

    // Signed operands are reduced to magnitudes; the sign is reapplied once at the end.
    assign w_a_neg = is_signed & a[WIDTH-1];
    assign w_b_neg = is_signed & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~a + WIDTH'(1)) : a;
    assign w_b_mag = w_b_neg ? (~b + WIDTH'(1)) : b;

    assign w_addend  = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
    assign w_acc_sum = r_mplier[0] ? (r_acc + w_addend) : r_acc;
    assign w_product = r_neg ? (~w_acc_sum + PW'(1)) : w_acc_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = start ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else if (w_load) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_sum;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                {r_res_hi, r_res_lo} <= w_product;
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign result_lo = r_res_lo;
    assign result_hi = r_res_hi;

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// tb/tb_alu_seq_multiplier.sv - scoreboard bench for alu_seq_multiplier
module tb_alu_seq_multiplier;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          is_signed;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result_lo;
    logic [W-1:0]  result_hi;

    logic [2*W-1:0] sb[$];
    int n_cmp;
    int n_err;
    int done_cnt;

    alu_seq_multiplier #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        if (s) begin
            sx = {{W{x[W-1]}}, x};
            sy = {{W{y[W-1]}}, y};
            return sx * sy;
        end
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
    endfunction

    // Output monitor: pops the scoreboard on every done cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("busy_done_excl", {63'b0, busy & done}, 64'd0);
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) check_eq("sb_underflow", 64'd1, 64'd0);
                else check_eq("product", {result_hi, result_lo}, sb.pop_front());
            end
        end
    end

    task automatic wait_done(input int lat0, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = 0;
        while (!done && lat < LAT + 60) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic ts, input logic [2*W-1:0] exp_v);
        int lat;
        int bcnt;
        start     = 1'b1;
        a         = ta;
        b         = tb_v;
        is_signed = ts;
        sb.push_back(exp_v);
        @(negedge clk);
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom);
        wait_done(1, lat, bcnt);
        check_eq({tag, "_latency"}, 64'(lat), 64'(LAT));
        check_eq({tag, "_busy_cycles"}, 64'(bcnt), 64'(W));
    endtask

    initial begin
        int lat;
        int bcnt;
        int d0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        n_cmp = 0; n_err = 0; done_cnt = 0;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {62'b0, busy, done}, 64'd0);
        check_eq("reset_result", {result_hi, result_lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("u_3x5",    32'd3,          32'd5,          1'b0, 64'h00000000_0000000F);
        do_op("u_max",    32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE_00000001);
        do_op("s_m3x7",   32'hFFFFFFFD,   32'd7,          1'b1, 64'hFFFFFFFF_FFFFFFEB);
        do_op("s_minmin", 32'h80000000,   32'h80000000,   1'b1, 64'h40000000_00000000);
        do_op("s_m1m1",   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 64'h00000000_00000001);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'(i & 1);
            do_op("rand", ra, rb, rs, model(ra, rb, rs));
            @(negedge clk);
        end

        // start re-pulsed during RUN must be ignored
        d0 = done_cnt;
        start = 1'b1; a = 32'd2; b = 32'd4; is_signed = 1'b0;
        sb.push_back(64'd8);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; a = 32'd9;
        @(negedge clk);
        start = 1'b0; a = '0;
        wait_done(11, lat, bcnt);
        check_eq("repulse_latency", 64'(lat), 64'(LAT));
        repeat (40) @(negedge clk);
        check_eq("repulse_done_count", 64'(done_cnt - d0), 64'd1);

        // start held in DONE chains a second operation
        do_op("chain_first", 32'd3, 32'd5, 1'b0, 64'd15);
        check_eq("chain_in_done", {63'b0, done}, 64'd1);
        do_op("chain_second", 32'd6, 32'd7, 1'b0, 64'd42);
        @(negedge clk);

        // reset in the middle of RUN discards the operation
        start = 1'b1; a = 32'd2; b = 32'd3; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("pre_reset_busy", {63'b0, busy}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrun_reset_flags", {62'b0, busy, done}, 64'd0);
        check_eq("midrun_reset_result", {result_hi, result_lo}, 64'd0);
        @(negedge clk);
        check_eq("post_reset_idle", {62'b0, busy, done}, 64'd0);
        do_op("after_reset", 32'd2, 32'd2, 1'b0, 64'd4);

        do_op("hold_10x10", 32'd10, 32'd10, 1'b0, 64'd100);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_eq("hold_lo", 64'(result_lo), 64'd100);
            check_eq("hold_done", {63'b0, done}, 64'd0);
        end

        check_eq("sb_leftover", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_multiplier.md
# alu_seq_multiplier

Iterative radix-2 shift-add multiplier for the ALU datapath. Accepts two WIDTH-bit operands on a start pulse and produces the full 2*WIDTH-bit product after a fixed latency. `result_lo` and `result_hi` feed data inputs of the ALU result-select multiplexer, serving as the MUL and MULH slots. `busy` and `done` let the control unit stall until the product is valid.

## Interface
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- start  input  1  request; sampled only in IDLE or DONE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while in RUN
- done  output  1  high for exactly the one cycle the FSM is in DONE
- result_lo  output  WIDTH  low half of product, registered
- result_hi  output  WIDTH  high half of product, registered

## Operation
- States: IDLE, RUN, DONE. Reset value of every output is 0; the FSM resets to IDLE.
- Counter and datapath:
  - Internal iteration counter is ceil(log2(WIDTH+1)) bits.
  - Internal accumulator is 2*WIDTH bits.
  - Operand magnitude registers are WIDTH bits, plus a neg_result flag.
- IDLE or DONE with start=1 (load):
  - If is_signed=1, load magnitudes |a| and |b| as WIDTH-bit unsigned values and set neg_result = a[MSB] XOR b[MSB].
  - If is_signed=0, load a and b unchanged and set neg_result = 0.
  - Clear the accumulator, set counter = 0, go to RUN.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) fits in WIDTH unsigned bits, so no overflow case exists.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - If multiplier LSB=1, add the multiplicand, shifted left by counter, into the accumulator.
  - Shift the multiplier right by 1 and increment the counter.
  - After the WIDTH-th iteration (counter reaches WIDTH), go to DONE.
  - Any equivalent shift-add ordering is acceptable as long as the cycle count matches.
- Entry to DONE:
  - `result_{hi,lo}` are written with the accumulator, two's-complement negated over 2*WIDTH bits when neg_result=1.
  - The results hold until the next load completes its computation. They are not cleared on entering IDLE or on a new start; only reset clears them.
- start during RUN: ignored. It is neither queued nor allowed to alter the in-flight operands.
- is_signed, a and b: don't-care in every cycle except the one in which start is accepted.
- rst_n=0 in any state, including mid-RUN: at the next edge go to IDLE and clear busy, done, the results, the counter and the accumulator. The in-flight operation is discarded.

## Timing
- Let edge E be the edge at which start is accepted. Then:
  - busy=1 in the cycles following edges E through E+WIDTH-1, i.e. WIDTH cycles.
  - done=1 and the results are valid in the cycle following edge E+WIDTH.
- Latency from start to done is WIDTH+1 cycles: 33 for WIDTH=32.
- Back-to-back operation: start held high during the DONE cycle is accepted. busy rises in the next cycle and done stays low until that operation completes. Sustained throughput is one product per WIDTH+1 cycles.
- busy and done are never high simultaneously.
- The outputs are registered with no combinational path from inputs, so the result mux sees stable values.

## Test plan
- Unsigned: a=3, b=5, is_signed=0, start pulse -> done 33 cycles later with hi=0x00000000, lo=0x0000000F; busy high for exactly 32 cycles.
- Unsigned max: a=b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed corner cases, each as a separate operation with is_signed=1:
  - a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
  - a=b=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001.
- Handshake:
  - start re-pulsed with a=9 in RUN cycle 10 of a 2*4 operation -> result 8, done once, no second done.
  - start held high through DONE with a=6, b=7 -> second done 33 cycles after the first, lo=42.
- Reset mid-run: rst_n=0 for one cycle at RUN cycle 16 -> next cycle busy=0, done=0, hi=lo=0, FSM in IDLE. A subsequent 2*2 operation yields lo=4 at normal latency.
- Hold: after a completed 10*10 operation, idle 50 cycles -> lo stays 100 and done stays 0 throughout.
